c880_resp_misr: RTL and testbench

Downstream response compactor for the c880 combinational benchmark (foobar). It consumes the 26-bit output vector each time the pattern source marks a response valid. Responses fold into a multiple-input signature register (MISR) over a fixed number of patterns. At the end it reports the final signature and a pass/fail compare against an expected signature, replacing per-pattern $monitor dumps in regression.

---
 rtl/c880_resp_misr.sv | 75 +++++++
 tb/tb_c880_resp_misr.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/c880_resp_misr.sv
// c880_resp_misr: folds c880 response vectors into a MISR over NPAT patterns and flags pass/fail against an expected signature
module c880_resp_misr #(
    parameter int RESP_W = 26,
    parameter int SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED = 32'h00000000,
    parameter int NPAT = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp,
    input  logic [SIG_W-1:0]  exp_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  pat_count
);
    if (NPAT < 1) begin : g_bad_npat
        $error("NPAT must be >= 1");
    end
    if (NPAT >= (1 << CNT_W)) begin : g_bad_cnt
        $error("NPAT must be < 2**CNT_W");
    end
    if (SIG_W < RESP_W) begin : g_bad_sig
        $error("SIG_W must be >= RESP_W");
    end
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NPAT - 1);
    state_t state, state_nx;
    logic [SIG_W-1:0] sig_step, sig_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic pass_nx;
    assign sig_step = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0) ^ SIG_W'(resp);
    assign busy = state == RUN;
    assign done = state == DONE;
    always_comb begin
        state_nx = state;
        sig_nx = signature;
        cnt_nx = pat_count;
        pass_nx = pass;
        if (state == RUN) begin
            if (resp_valid) begin
                sig_nx = sig_step;
                cnt_nx = pat_count + 1'b1;
                if (pat_count == LAST) begin
                    state_nx = DONE;
                    pass_nx = sig_step == exp_sig;
                end
            end
        end else if (start) begin
            // start takes priority over a coincident response, which is dropped
            state_nx = RUN;
            sig_nx = SEED;
            cnt_nx = '0;
            pass_nx = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            signature <= '0;
            pat_count <= '0;
            pass <= 1'b0;
        end else begin
            state <= state_nx;
            signature <= sig_nx;
            pat_count <= cnt_nx;
            pass <= pass_nx;
        end
    end
endmodule

// File: tb/tb_c880_resp_misr.sv
// tb_c880_resp_misr: table-driven and randomized checks of the response MISR against a queue-based signature model
module tb_c880_resp_misr;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic resp_valid = 1'b0;
    logic [25:0] resp = '0;
    logic [31:0] e8 = '0, e1 = '0, e2 = '0, ef = '0;
    logic busy8, done8, pass8, busy1, done1, pass1, busy2, done2, pass2, busyf, donef, passf;
    logic [31:0] sig8, sig1, sig2, sigf;
    logic [15:0] cnt8, cnt1, cnt2, cntf;
    int total = 0;
    int bad = 0;
    logic [25:0] mq[$];

    always #5 clk = ~clk;

    c880_resp_misr u_dut (.clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp(resp),
        .exp_sig(e8), .busy(busy8), .done(done8), .pass(pass8), .signature(sig8), .pat_count(cnt8));
    c880_resp_misr #(.NPAT(1)) u_n1 (.clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp(resp),
        .exp_sig(e1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .pat_count(cnt1));
    c880_resp_misr #(.NPAT(2)) u_n2 (.clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp(resp),
        .exp_sig(e2), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .pat_count(cnt2));
    c880_resp_misr #(.NPAT(1), .SEED(32'h80000000)) u_fb (.clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid),
        .resp(resp), .exp_sig(ef), .busy(busyf), .done(donef), .pass(passf), .signature(sigf), .pat_count(cntf));

    // signature as polynomial arithmetic over the list of accepted responses
    function automatic logic [31:0] fold(input logic [31:0] seed);
        logic [31:0] s;
        logic [32:0] t;
        s = seed;
        foreach (mq[i]) begin
            t = {s, 1'b0};
            s = t[31:0] ^ (t[32] ? POLY : 32'h0) ^ {6'h0, mq[i]};
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick(input logic s, input logic v, input logic [25:0] r);
        start = s;
        resp_valid = v;
        resp = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1'b0, 1'b0, '0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic s;
        logic v;
        logic [25:0] r;
        logic acc;
        logic [15:0] cnt;
        logic busy;
        logic done;
    } vec_t;

    vec_t tbl[12];
    logic [25:0] pats[8];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 26'h5,       1'b0, 16'd0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 26'h1,       1'b1, 16'd1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 26'h3FFFFFF, 1'b0, 16'd1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 26'h2,       1'b1, 16'd2, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 26'h2000000, 1'b1, 16'd3, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 26'h3FFFFFF, 1'b1, 16'd4, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 26'h1234567, 1'b1, 16'd5, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 26'h0,       1'b1, 16'd6, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 26'h2AAAAAA, 1'b1, 16'd7, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 26'h1555555, 1'b1, 16'd8, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 26'h0ABCDEF, 1'b0, 16'd8, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 26'h3000001, 1'b0, 16'd8, 1'b0, 1'b1};

        tick(1'b1, 1'b1, 26'h1);
        tick(1'b1, 1'b0, 26'h1);
        rst_n = 1'b1;
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_pass", 64'(pass8), 64'd0);
        chk("rst_sig", 64'(sig8), 64'd0);
        chk("rst_cnt", 64'(cnt8), 64'd0);
        chk("rst_sig_fb", 64'(sigf), 64'd0);

        mq.delete();
        foreach (tbl[i]) begin
            tick(tbl[i].s, tbl[i].v, tbl[i].r);
            if (tbl[i].acc) mq.push_back(tbl[i].r);
            chk($sformatf("tbl%0d_cnt", i), 64'(cnt8), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_busy", i), 64'(busy8), 64'(tbl[i].busy));
            chk($sformatf("tbl%0d_done", i), 64'(done8), 64'(tbl[i].done));
            chk($sformatf("tbl%0d_sig", i), 64'(sig8), 64'(fold(32'h0)));
        end

        tick(1'b1, 1'b0, '0);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 26'(k + 7));
        do_reset();
        chk("midrst_busy", 64'(busy8), 64'd0);
        chk("midrst_done", 64'(done8), 64'd0);
        chk("midrst_sig", 64'(sig8), 64'd0);
        chk("midrst_cnt", 64'(cnt8), 64'd0);

        for (int run = 0; run < 8; run++) begin
            logic want_pass;
            mq.delete();
            for (int k = 0; k < 8; k++) pats[k] = 26'($urandom);
            for (int k = 0; k < 8; k++) mq.push_back(pats[k]);
            want_pass = run[0];
            e8 = fold(32'h0) ^ (want_pass ? 32'h0 : 32'(1 << $urandom_range(0, 31)));
            tick(1'b1, 1'b0, '0);
            for (int k = 0; k < 8; k++) begin
                int gap;
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 26'($urandom));
                chk("rnd_done_early", 64'(done8), 64'd0);
                tick(1'b0, 1'b1, pats[k]);
            end
            chk("rnd_sig", 64'(sig8), 64'(fold(32'h0)));
            chk("rnd_cnt", 64'(cnt8), 64'd8);
            chk("rnd_done", 64'(done8), 64'd1);
            chk("rnd_pass", 64'(pass8), 64'(want_pass));
        end

        mq.delete();
        for (int k = 0; k < 8; k++) mq.push_back(pats[k]);
        e8 = fold(32'h0);
        pats[5] = pats[5] ^ 26'h0000400;
        tick(1'b1, 1'b0, '0);
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b1, pats[k]);
        chk("flip_done", 64'(done8), 64'd1);
        chk("flip_pass", 64'(pass8), 64'd0);

        do_reset();
        e1 = 32'h1;
        e2 = 32'h3;
        tick(1'b1, 1'b0, '0);
        chk("n1_busy", 64'(busy1), 64'd1);
        chk("n1_done_pre", 64'(done1), 64'd0);
        tick(1'b0, 1'b1, 26'h1);
        chk("n1_sig", 64'(sig1), 64'h1);
        chk("n1_done", 64'(done1), 64'd1);
        chk("n1_pass", 64'(pass1), 64'd1);
        chk("n2_done_mid", 64'(done2), 64'd0);
        for (int g = 0; g < 3; g++) tick(1'b0, 1'b0, 26'h1);
        tick(1'b0, 1'b1, 26'h1);
        chk("n2_sig", 64'(sig2), 64'h3);
        chk("n2_cnt", 64'(cnt2), 64'd2);
        chk("n2_pass", 64'(pass2), 64'd1);
        chk("n1_cnt_cap", 64'(cnt1), 64'd1);

        e2 = 32'h4;
        tick(1'b1, 1'b0, '0);
        tick(1'b0, 1'b1, 26'h1);
        for (int g = 0; g < 3; g++) tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 26'h1);
        chk("n2_fail_done", 64'(done2), 64'd1);
        chk("n2_fail_pass", 64'(pass2), 64'd0);

        do_reset();
        ef = 32'h04C11DB7;
        tick(1'b1, 1'b0, '0);
        chk("fb_seed", 64'(sigf), 64'h80000000);
        tick(1'b0, 1'b1, 26'h0);
        chk("fb_sig", 64'(sigf), 64'h04C11DB7);
        chk("fb_pass", 64'(passf), 64'd1);
        chk("fb_done", 64'(donef), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
